conv_accumulator: RTL and testbench

Sequential signed accumulator that sums a fixed-length window of NUM_TERMS operands plus a bias, one operand per accepted beat. It produces one saturated or wrapped DATA_WIDTH result per window. It sits after the multiplier array in a convolution lane and feeds the activation/pooling stage, replacing a free-running combinational adder chain with a handshaked, overflow-safe unit.

---
 rtl/conv_accumulator_pkg.sv | 29 ++
 rtl/conv_accumulator_if.sv | 47 ++++
 rtl/conv_accumulator_sat_narrow.sv | 42 ++++
 rtl/conv_accumulator.sv | 117 +++++++++++
 tb/tb_conv_accumulator.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_accumulator_pkg.sv
// conv_accumulator_pkg
//   Shared types and helpers for the convolution-lane accumulator:
//   - state_t        : accumulator FSM states
//   - acc_width()    : internal accumulator width, wide enough that a full
//                      window of operands plus bias can never overflow
//   - smax()/smin()  : two's complement limits of a given width
package conv_accumulator_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // NUM_TERMS operands plus one bias give NUM_TERMS+1 addends, so
  // clog2(NUM_TERMS+1) guard bits are enough.
  function automatic int acc_width(input int dw, input int nt);
    return dw + $clog2(nt + 1);
  endfunction

  // Limits are returned 64 bits wide; callers narrow them to their own width.
  function automatic logic signed [63:0] smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_accumulator_if.sv
// conv_accumulator_if
//   Handshake bundle between a convolution-lane accumulator and its
//   neighbours.
//   Upstream side  : in_valid/in_ready/in_data, bias, clear
//   Downstream side: out_valid/out_ready/out_data, out_ovf
//   Modports:
//   - slave  : the accumulator itself
//   - master : whatever drives operands and consumes results
interface conv_accumulator_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] bias;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ovf;

  modport slave (
    input  clear,
    input  in_valid,
    output in_ready,
    input  in_data,
    input  bias,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_ovf
  );

  modport master (
    output clear,
    output in_valid,
    input  in_ready,
    output in_data,
    output bias,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_ovf
  );

endinterface

// File: rtl/conv_accumulator_sat_narrow.sv
// sat_narrow
//   Combinational narrowing of a signed IN_WIDTH value to OUT_WIDTH.
//   Ports:
//   - din  : signed wide value
//   - dout : narrowed value; clamped to the OUT_WIDTH signed range when
//            SATURATE=1, otherwise the low OUT_WIDTH bits (wrap)
//   - ovf  : din lies outside the OUT_WIDTH signed range (independent of
//            SATURATE)
module sat_narrow
  import conv_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic        [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  localparam logic signed [IN_WIDTH-1:0] MAXV = IN_WIDTH'(smax(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MINV = IN_WIDTH'(smin(OUT_WIDTH));

  logic hi;
  logic lo;

  assign hi  = (din > MAXV);
  assign lo  = (din < MINV);
  assign ovf = hi | lo;

  always_comb begin
    dout = din[OUT_WIDTH-1:0];
    if (SATURATE) begin
      if (hi) begin
        dout = MAXV[OUT_WIDTH-1:0];
      end else if (lo) begin
        dout = MINV[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// conv_accumulator
//   Handshaked signed accumulator for one convolution lane. Sums a window of
//   NUM_TERMS operands plus a bias (bias sampled on the window's first beat)
//   and presents one saturated or wrapped DATA_WIDTH result per window.
//   Ports:
//   - clk : rising-edge clock
//   - rst : synchronous active-high reset
//   - bus : conv_accumulator_if slave
//           in_valid/in_ready/in_data/bias : operand beats
//           out_valid/out_ready/out_data   : result, held until accepted
//           out_ovf                        : window sum left DATA_WIDTH range
//           clear                          : abort window and pending result
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_ACC  | collecting operands, cnt = beats accepted so far
//   ST_HOLD | result registered on out_*, waiting for out_ready
module conv_accumulator
  import conv_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TERMS  = 9,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  conv_accumulator_if.slave   bus
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, NUM_TERMS);
  localparam int CNT_WIDTH = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_TERMS - 1);
  localparam int EXT = ACC_WIDTH - DATA_WIDTH;

  state_t                       state;
  logic        [CNT_WIDTH-1:0]  cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  data_ext;
  logic        [DATA_WIDTH-1:0] narrow_data;
  logic                         narrow_ovf;
  logic                         out_valid_q;
  logic        [DATA_WIDTH-1:0] out_data_q;
  logic                         out_ovf_q;

  assign bias_ext = {{EXT{bus.bias[DATA_WIDTH-1]}}, bus.bias};
  assign data_ext = {{EXT{bus.in_data[DATA_WIDTH-1]}}, bus.in_data};

  // The first beat of a window restarts from the bias instead of the
  // previous window's sum, so acc never needs an explicit reload.
  assign acc_base = (cnt == '0) ? bias_ext : acc;
  assign acc_next = acc_base + data_ext;

  sat_narrow #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_narrow (
    .din  (acc_next),
    .dout (narrow_data),
    .ovf  (narrow_ovf)
  );

  // Gated by rst/clear so that a beat offered in those cycles is visibly
  // refused rather than silently dropped.
  assign bus.in_ready  = (state == ST_ACC) && !rst && !bus.clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ACC;
      cnt         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      // out_data is deliberately left alone.
      state       <= ST_ACC;
      cnt         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.in_valid) begin
            acc <= acc_next;
            if (cnt == CNT_LAST) begin
              out_data_q  <= narrow_data;
              out_ovf_q   <= narrow_ovf;
              out_valid_q <= 1'b1;
              cnt         <= '0;
              state       <= ST_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
module tb_conv_accumulator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_accumulator_if #(.DATA_WIDTH(8)) ifm ();
  conv_accumulator_if #(.DATA_WIDTH(8)) ifw ();
  conv_accumulator_if #(.DATA_WIDTH(8)) if1 ();

  // Wrap instance follows the saturating one beat for beat.
  assign ifw.clear     = ifm.clear;
  assign ifw.in_valid  = ifm.in_valid;
  assign ifw.in_data   = ifm.in_data;
  assign ifw.bias      = ifm.bias;
  assign ifw.out_ready = ifm.out_ready;

  conv_accumulator #(.DATA_WIDTH(8), .NUM_TERMS(3), .SATURATE(1'b1)) dut_sat (
    .clk (clk), .rst (rst), .bus (ifm.slave));
  conv_accumulator #(.DATA_WIDTH(8), .NUM_TERMS(3), .SATURATE(1'b0)) dut_wrap (
    .clk (clk), .rst (rst), .bus (ifw.slave));
  conv_accumulator #(.DATA_WIDTH(8), .NUM_TERMS(1), .SATURATE(1'b1)) dut_n1 (
    .clk (clk), .rst (rst), .bus (if1.slave));

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] qs[$];  // {ovf, data} expected from dut_sat
  logic [8:0] qw[$];  // {ovf, data} expected from dut_wrap

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop on every completed output handshake.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && !ifm.clear && ifm.out_valid) begin
      check("sat_in_ready_in_hold", ifm.in_ready, 0);
      if (ifm.out_ready) begin
        if (qs.size() == 0) begin
          check("sat_unexpected_output", ifm.out_data, 9'h1ff);
        end else begin
          e = qs.pop_front();
          check("sat_out_data", ifm.out_data, e[7:0]);
          check("sat_out_ovf", ifm.out_ovf, e[8]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && !ifw.clear && ifw.out_valid) begin
      check("wrap_in_ready_in_hold", ifw.in_ready, 0);
      if (ifw.out_ready) begin
        if (qw.size() == 0) begin
          check("wrap_unexpected_output", ifw.out_data, 9'h1ff);
        end else begin
          e = qw.pop_front();
          check("wrap_out_data", ifw.out_data, e[7:0]);
          check("wrap_out_ovf", ifw.out_ovf, e[8]);
        end
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic beat(input int b, input int d);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    ifm.in_valid = 1'b1;
    ifm.in_data  = 8'(d);
    ifm.bias     = 8'(b);
    do begin
      @(negedge clk);
      ok = ifm.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    check("beat_accepted", ok, 1);
    ifm.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Later beats carry an inverted bias to show it is only sampled once.
  task automatic window(input int b, input int d0, input int d1, input int d2,
                        input int es, input int ew, input bit eo, input int gap);
    qs.push_back({eo, 8'(es)});
    qw.push_back({eo, 8'(ew)});
    beat(b, d0);
    idle(gap);
    beat(~b, d1);
    idle(gap);
    beat(~b, d2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qs.size() != 0 || qw.size() != 0) && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_queues_empty", 32'(qs.size() + qw.size()), 0);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifm.out_valid && n < 50);
    check("out_valid_rises", ifm.out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifm.clear = 1'b0; ifm.in_valid = 1'b0; ifm.in_data = '0; ifm.bias = '0;
    ifm.out_ready = 1'b1;
    if1.clear = 1'b0; if1.in_valid = 1'b0; if1.in_data = '0; if1.bias = '0;
    if1.out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("in_ready_during_rst", ifm.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", ifm.in_ready, 1);
    check("rst_out_valid", ifm.out_valid, 0);
    check("rst_out_data", ifm.out_data, 0);
    check("rst_out_ovf", ifm.out_ovf, 0);
    check("rst_wrap_out_data", ifw.out_data, 0);
    check("rst_n1_in_ready", if1.in_ready, 1);
    @(posedge clk); #1;

    // Basic window: 10+1+2+3 = 16, one-cycle out_valid
    window(10, 1, 2, 3, 16, 16, 1'b0, 0);
    @(negedge clk);
    check("basic_out_valid_high", ifm.out_valid, 1);
    check("basic_in_ready_low", ifm.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("basic_out_valid_one_cycle", ifm.out_valid, 0);
    @(posedge clk); #1;
    drain();

    // Positive overflow: 290 -> sat 127, wrap 0x22
    window(100, 100, 100, -10, 127, 8'h22, 1'b1, 0);
    // Negative overflow: -512 -> sat 0x80, wrap 0x00
    window(-128, -128, -128, -128, 8'h80, 8'h00, 1'b1, 0);
    window(-128, -128, -128, -128, 8'h80, 8'h00, 1'b1, 2);
    // Range boundaries: exactly 127 fits, 128 does not
    window(127, 0, 0, 0, 127, 127, 1'b0, 0);
    window(127, 1, 0, 0, 127, 8'h80, 1'b1, 0);
    // Negative in range: -5-10+3-1 = -13
    window(-5, -10, 3, -1, -13, -13, 1'b0, 1);
    drain();

    // Backpressure: 20+5+5+5 = 35 held for 5 cycles
    ifm.out_ready = 1'b0;
    window(20, 5, 5, 5, 35, 35, 1'b0, 0);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", ifm.out_valid, 1);
      check("bp_out_data", ifm.out_data, 35);
      check("bp_out_ovf", ifm.out_ovf, 0);
      check("bp_in_ready", ifm.in_ready, 0);
    end
    @(posedge clk); #1;
    ifm.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_out_valid_falls", ifm.out_valid, 0);
    @(posedge clk); #1;
    window(0, 1, 1, 1, 3, 3, 1'b0, 0);
    drain();

    // Clear mid-window, with a beat offered in the clear cycle
    beat(50, 9);
    beat(50, 9);
    ifm.clear    = 1'b1;
    ifm.in_valid = 1'b1;
    ifm.in_data  = 8'd77;
    @(negedge clk);
    check("clear_in_ready_low", ifm.in_ready, 0);
    @(posedge clk); #1;
    ifm.clear    = 1'b0;
    ifm.in_valid = 1'b0;
    window(0, 5, 5, 5, 15, 15, 1'b0, 0);
    drain();

    // Reset mid-window
    beat(50, 9);
    beat(50, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_data", ifm.out_data, 0);
    check("midrst_in_ready", ifm.in_ready, 1);
    @(posedge clk); #1;
    window(0, 5, 5, 5, 15, 15, 1'b0, 0);
    drain();

    // Clear while holding a result: 1+1+1+1 = 4 dropped without handshake
    ifm.out_ready = 1'b0;
    window(1, 1, 1, 1, 4, 4, 1'b0, 0);
    wait_out_valid();
    @(posedge clk); #1;
    ifm.clear = 1'b1;
    @(posedge clk); #1;
    ifm.clear = 1'b0;
    @(negedge clk);
    check("hold_clear_out_valid", ifm.out_valid, 0);
    check("hold_clear_out_data_kept", ifm.out_data, 4);
    check("hold_clear_in_ready", ifm.in_ready, 1);
    check("hold_clear_wrap_out_valid", ifw.out_valid, 0);
    void'(qs.pop_front());
    void'(qw.pop_front());
    @(posedge clk); #1;
    ifm.out_ready = 1'b1;
    idle(3);

    // NUM_TERMS=1: -3+7 = 4, one result every other cycle
    if1.bias     = 8'(-3);
    if1.in_data  = 8'd7;
    if1.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("n1_out_valid_pattern", if1.out_valid, 32'(i % 2));
      if (if1.out_valid) begin
        check("n1_out_data", if1.out_data, 4);
        check("n1_out_ovf", if1.out_ovf, 0);
      end
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    idle(3);

    check("final_sat_queue_empty", 32'(qs.size()), 0);
    check("final_wrap_queue_empty", 32'(qw.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
